// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the load/store path.
// Data requests win contention until STARVE_MAX consecutive contended wins, then fetch is forced.
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   if_req/if_addr -> if_gnt         fetch request; grant is combinational, IDLE only
//   if_rvalid/if_rdata               one-cycle pulse with registered fetched word
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt   data request; grant is combinational, IDLE only
//   d_rvalid/d_rdata                 one-cycle pulse: load data valid or store complete
//   mem_req/we/addr/wdata/wstrb      latched request, held until mem_ready
//   mem_ready/mem_rdata              memory completion and read data
//   busy                             an access is in flight
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    state_t state, state_n;
    logic [CW-1:0] starve_cnt;
    logic d_win, idle, done;
    always_comb begin
        idle    = state == IDLE;
        done    = !idle && mem_ready;
        d_win   = d_req && (!if_req || starve_cnt < CW'(STARVE_MAX));
        d_gnt   = idle && d_win;
        if_gnt  = idle && if_req && !d_win;
        state_n = idle ? (d_gnt ? DATA : if_gnt ? FETCH : IDLE) : (mem_ready ? IDLE : state);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    assign busy = !idle;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_rvalid <= done && state == FETCH;
            d_rvalid  <= done && state == DATA;
            // only contended data wins count towards fetch starvation
            if (if_gnt) starve_cnt <= '0;
            else if (d_gnt && if_req) starve_cnt <= starve_cnt + CW'(1);
            if (d_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_we ? d_wstrb : '0;
            end else if (if_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end else if (done) begin
                mem_req   <= 1'b0;
            end
            if (done && state == FETCH) if_rdata <= mem_rdata;
            if (done && state == DATA && !mem_we) d_rdata <= mem_rdata;
        end
    end
endmodule
